// File: rtl/q_max_select.sv
// q_max_select: scans one frame of IEEE-754 single-precision Q-values coming
// from target_net. It returns the largest value and its arrival index one cycle
// after the last value. A terminal frame forces the returned value to zero.
module q_max_select #(
   parameter int DATA_WIDTH            = 32,
   parameter int NUMBER_OF_OUTPUT_NODE = 3,
   parameter int INDEX_WIDTH           = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_valid,
   input  logic [DATA_WIDTH-1:0]  i_data,
   input  logic                   i_done,
   output logic [DATA_WIDTH-1:0]  o_data,
   output logic [INDEX_WIDTH-1:0] o_index,
   output logic                   o_valid
);

   // One extra bit so the counter can never wrap before the frame ends.
   localparam int               CNT_W = INDEX_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUMBER_OF_OUTPUT_NODE - 1);
   localparam bit               ONE   = (NUMBER_OF_OUTPUT_NODE == 1);

   typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [DATA_WIDTH-1:0]  run_max;
   logic [INDEX_WIDTH-1:0] run_idx;
   logic                   done_q;
   logic                   first_take;
   logic                   take_new;

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   // Strict a > b on raw float bits. A NaN in 'a' never wins, and any non-NaN
   // beats a NaN in 'b'. Because of this, a frame that is all NaN keeps its
   // first element.
   function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
      logic res;
      if (is_nan(a))
         res = 1'b0;
      else if (is_nan(b))
         res = 1'b1;
      else if (!a[31] && !b[31])
         res = (a[30:0] > b[30:0]);
      else if (a[31] && b[31])
         res = (a[30:0] < b[30:0]);
      else if (!a[31])
         res = !((a[30:0] == 31'd0) && (b[30:0] == 31'd0)); // +0 == -0
      else
         res = 1'b0;
      return res;
   endfunction

   assign take_new = f_gt(i_data, run_max);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state. In OUT, a new value is accepted as the first element of the next frame.
   always_comb begin
      state_nxt  = state;
      first_take = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid) begin
               first_take = 1'b1;
               state_nxt  = ONE ? OUT : COLLECT;
            end
         end
         COLLECT: begin
            if (i_valid && (cnt == LAST)) state_nxt = OUT;
         end
         OUT: begin
            if (i_valid) begin
               first_take = 1'b1;
               state_nxt  = ONE ? OUT : COLLECT;
            end else begin
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Running max/index tracking and the registered result. A new frame can
   // start on the same edge that publishes the previous result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         run_max <= '0;
         run_idx <= '0;
         done_q  <= 1'b0;
         o_data  <= '0;
         o_index <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= (state == OUT);
         if (state == OUT) begin
            o_data  <= done_q ? '0 : run_max;
            o_index <= run_idx;
            cnt     <= '0;
         end
         if (first_take) begin
            run_max <= i_data;
            run_idx <= '0;
            done_q  <= i_done;
            cnt     <= CNT_W'(1);
         end else if ((state == COLLECT) && i_valid) begin
            cnt <= cnt + 1'b1;
            if (take_new) begin
               run_max <= i_data;
               run_idx <= cnt[INDEX_WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_q_max_select.sv
// Directed bench for q_max_select: a table of three-value frames plus
// hand-written back-to-back and mid-frame reset sequences.
module tb_q_max_select;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_data;
   logic        i_done;
   logic [31:0] o_data;
   logic [1:0]  o_index;
   logic        o_valid;

   int n_vec  = 0;
   int n_fail = 0;
   int pulses = 0;

   q_max_select #(.DATA_WIDTH(32), .NUMBER_OF_OUTPUT_NODE(3), .INDEX_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_done(i_done),
      .o_data(o_data), .o_index(o_index), .o_valid(o_valid)
   );

   always #5 clk = ~clk;

   // Count result pulses away from the active edge.
   always @(negedge clk) if (o_valid === 1'b1) pulses++;

   typedef struct {
      string       name;
      logic [31:0] d0, d1, d2;
      logic        done;
      logic [31:0] ed;
      logic [1:0]  ei;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] v, input logic d);
      i_valid = 1'b1;
      i_data  = v;
      i_done  = d;
      tick();
      i_valid = 1'b0;
      i_done  = 1'b0;
   endtask

   // Send one frame with gaps. Later elements carry the opposite i_done to
   // show that the flag is only taken from the first element. Then check the
   // timing, value and hold of the result pulse.
   task automatic send_frame(input vec_t v, input int g);
      drive(v.d0, v.done);
      repeat (g % 4) tick();
      drive(v.d1, ~v.done);
      repeat ((g + 1) % 4) tick();
      drive(v.d2, ~v.done);
      chk({v.name, ".early"}, {31'd0, o_valid}, 32'd0);
      tick();
      chk({v.name, ".valid"}, {31'd0, o_valid}, 32'd1);
      chk({v.name, ".data"},  o_data, v.ed);
      chk({v.name, ".index"}, {30'd0, o_index}, {30'd0, v.ei});
      tick();
      chk({v.name, ".drop"},  {31'd0, o_valid}, 32'd0);
      chk({v.name, ".hold"},  o_data, v.ed);
   endtask

   initial begin
      logic [31:0] b2b[6];
      logic        exp_v[7];

      tbl[0] = '{"basic",   32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, 32'h40000000, 2'd1};
      tbl[1] = '{"negtie",  32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0, 32'hBF800000, 2'd0};
      tbl[2] = '{"zeros",   32'h80000000, 32'h00000000, 32'hBF800000, 1'b0, 32'h80000000, 2'd0};
      tbl[3] = '{"term",    32'h40400000, 32'h7FC00000, 32'h41200000, 1'b1, 32'h00000000, 2'd2};
      tbl[4] = '{"nanskip", 32'h40400000, 32'h7FC00000, 32'h41200000, 1'b0, 32'h41200000, 2'd2};
      tbl[5] = '{"allnan",  32'h7FC00000, 32'h7F800001, 32'hFFC00000, 1'b0, 32'h7FC00000, 2'd0};
      tbl[6] = '{"inf",     32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 2'd1};
      tbl[7] = '{"eqtie",   32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 2'd0};
      tbl[8] = '{"nanfirst",32'h7FC00000, 32'hC0A00000, 32'hC0400000, 1'b0, 32'hC0400000, 2'd2};
      tbl[9] = '{"neginf",  32'hFF800000, 32'h7FC00000, 32'hBF800000, 1'b0, 32'hBF800000, 2'd2};

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_done  = 1'b0;
      tick();
      tick();
      chk("rst.valid", {31'd0, o_valid}, 32'd0);
      chk("rst.data",  o_data, 32'd0);
      chk("rst.index", {30'd0, o_index}, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 10; k++) send_frame(tbl[k], k);

      // Back-to-back: six values with no gaps, so a new frame starts during OUT.
      b2b   = '{32'h3F800000, 32'h40400000, 32'h40000000,
                32'h40A00000, 32'h40800000, 32'h40C00000};
      exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         if (k < 6) begin
            i_valid = 1'b1;
            i_data  = b2b[k];
         end else begin
            i_valid = 1'b0;
         end
         tick();
         chk($sformatf("b2b.valid%0d", k), {31'd0, o_valid}, {31'd0, exp_v[k]});
         if (k == 3) begin
            chk("b2b.data1",  o_data, 32'h40400000);
            chk("b2b.index1", {30'd0, o_index}, 32'd1);
         end
         if (k == 6) begin
            chk("b2b.data2",  o_data, 32'h40C00000);
            chk("b2b.index2", {30'd0, o_index}, 32'd2);
         end
      end
      i_valid = 1'b0;
      tick();
      chk("b2b.pulses", pulses, 32'd2);

      // Reset mid-frame: the partial frame must vanish without producing a result.
      pulses = 0;
      drive(32'h40800000, 1'b0);
      drive(32'h40A00000, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst.valid", {31'd0, o_valid}, 32'd0);
      chk("midrst.data",  o_data, 32'd0);
      tick();
      send_frame('{"midrst", 32'h3F800000, 32'h3F000000, 32'h3E800000, 1'b0, 32'h3F800000, 2'd0}, 0);
      repeat (3) tick();
      chk("midrst.pulses", pulses, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
